ahb_cmd_master: RTL

Single-outstanding AHB-Lite master that turns a simple valid/ready command stream into NONSEQ/SINGLE AHB transfers. It returns one read-data/status response per command. It sits directly upstream of the AHB slave BFM/memory model and drives its HSEL/HADDR/HTRANS/HWDATA inputs. It consumes HRDATA/HREADYOUT/HRESP from that slave. In single-slave benches the slave's HREADYIN is tied to its own HREADYOUT; this block's HREADY input is driven from the same net.

---
 rtl/ahb_cmd_master.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/ahb_cmd_master.sv
// rtl/ahb_cmd_master.sv - single-outstanding AHB-Lite master for a valid/ready command stream
//
// Turns each accepted command into one NONSEQ/SINGLE AHB-Lite transfer and returns one
// response per command. A command that is illegal (HSIZE above word, or an address
// misaligned for its size) never reaches the bus and is answered with an error.
//
// Parameters
//   AWIDTH   address width, matches the slave HADDR width (>= 2)
//   TIMEOUT  consecutive wait-state cycles in one data phase that set TIMEOUT_ERR (2..65535)
//   TPD      output delay of the surrounding simulation model in ns; this RTL is zero-delay
//
// Ports
//   HCLK, HRESETN                     clock (rising edge), asynchronous active-low reset
//   CMD_VALID/CMD_READY               command handshake
//   CMD_WRITE/ADDR/SIZE/WDATA         command payload, sampled only on accept
//   RSP_VALID/RSP_READY               response handshake, payload held until accepted
//   RSP_RDATA/RSP_ERROR               read data (0 for writes and errors), error flag
//   HSEL/HADDR/HTRANS/HWRITE/HSIZE    AHB address phase
//   HBURST/HMASTLOCK/HPROT            constant SINGLE / unlocked / data, privileged
//   HWDATA                            write data, driven only in the data phase
//   HRDATA/HREADY/HRESP               slave response
//   XFER_CNT                          completed bus transfers (wraps), errored ones included
//   TIMEOUT_ERR                       sticky wait-state timeout flag

module ahb_cmd_master #(
  parameter int AWIDTH  = 10,
  parameter int TIMEOUT = 256,
  parameter int TPD     = 1
) (
  input  logic              HCLK,
  input  logic              HRESETN,
  input  logic              CMD_VALID,
  output logic              CMD_READY,
  input  logic              CMD_WRITE,
  input  logic [AWIDTH-1:0] CMD_ADDR,
  input  logic [2:0]        CMD_SIZE,
  input  logic [31:0]       CMD_WDATA,
  output logic              RSP_VALID,
  input  logic              RSP_READY,
  output logic [31:0]       RSP_RDATA,
  output logic              RSP_ERROR,
  output logic              HSEL,
  output logic [AWIDTH-1:0] HADDR,
  output logic [1:0]        HTRANS,
  output logic              HWRITE,
  output logic [2:0]        HSIZE,
  output logic [2:0]        HBURST,
  output logic              HMASTLOCK,
  output logic [3:0]        HPROT,
  output logic [31:0]       HWDATA,
  input  logic [31:0]       HRDATA,
  input  logic              HREADY,
  input  logic              HRESP,
  output logic [15:0]       XFER_CNT,
  output logic              TIMEOUT_ERR
);

  if (AWIDTH < 2 || TIMEOUT < 2 || TIMEOUT > 65535 || TPD < 0) begin : g_param_check
    $error("ahb_cmd_master: AWIDTH >= 2, TIMEOUT in 2..65535 and TPD >= 0 required");
  end

  localparam logic [15:0] TIMEOUT_LIM    = 16'(TIMEOUT);
  localparam logic [1:0]  HTRANS_IDLE    = 2'b00;
  localparam logic [1:0]  HTRANS_NONSEQ  = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2,
    S_RESP = 2'd3
  } state_t;

  state_t             state_q;
  state_t             state_d;

  logic               cmd_ready_q;
  logic               cmd_write_q;
  logic [AWIDTH-1:0]  cmd_addr_q;
  logic [2:0]         cmd_size_q;
  logic [31:0]        cmd_wdata_q;
  logic [31:0]        rsp_rdata_q;
  logic               rsp_error_q;
  logic [15:0]        xfer_cnt_q;
  logic [15:0]        wait_cnt_q;
  logic               timeout_err_q;

  logic               cmd_accept;
  logic               cmd_illegal;
  logic               data_entry;
  logic               data_done;
  logic               wait_cycle;

  // Size/alignment legality of the command currently offered.
  always_comb begin
    cmd_illegal = 1'b0;
    if (CMD_SIZE > 3'd2) begin
      cmd_illegal = 1'b1;
    end else if (CMD_SIZE == 3'd1 && CMD_ADDR[0]) begin
      cmd_illegal = 1'b1;
    end else if (CMD_SIZE == 3'd2 && CMD_ADDR[1:0] != 2'b00) begin
      cmd_illegal = 1'b1;
    end
  end

  assign cmd_accept = CMD_VALID && cmd_ready_q && (state_q == S_IDLE);
  // ADDR is held while a previous data phase extends, so the data phase starts on HREADY.
  assign data_entry = (state_q == S_ADDR) && HREADY;
  assign data_done  = (state_q == S_DATA) && HREADY;
  // The first cycle of a two-cycle ERROR response is not a wait state.
  assign wait_cycle = (state_q == S_DATA) && !HREADY && !HRESP;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_accept) begin
          state_d = cmd_illegal ? S_RESP : S_ADDR;
        end
      end
      S_ADDR: begin
        if (HREADY) begin
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (HREADY) begin
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (RSP_READY) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETN) begin
    if (!HRESETN) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Registered from the next state: stays low for the first edge after reset and
  // drops on the accept edge itself, so a second command cannot slip in.
  always_ff @(posedge HCLK or negedge HRESETN) begin
    if (!HRESETN) begin
      cmd_ready_q <= 1'b0;
    end else begin
      cmd_ready_q <= (state_d == S_IDLE);
    end
  end

  always_ff @(posedge HCLK or negedge HRESETN) begin
    if (!HRESETN) begin
      cmd_write_q <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_size_q  <= 3'd0;
      cmd_wdata_q <= 32'd0;
    end else if (cmd_accept) begin
      cmd_write_q <= CMD_WRITE;
      cmd_addr_q  <= CMD_ADDR;
      cmd_size_q  <= CMD_SIZE;
      cmd_wdata_q <= CMD_WDATA;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETN) begin
    if (!HRESETN) begin
      rsp_rdata_q <= 32'd0;
      rsp_error_q <= 1'b0;
    end else if (cmd_accept && cmd_illegal) begin
      rsp_rdata_q <= 32'd0;
      rsp_error_q <= 1'b1;
    end else if (data_done) begin
      rsp_rdata_q <= (cmd_write_q || HRESP) ? 32'd0 : HRDATA;
      rsp_error_q <= HRESP;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETN) begin
    if (!HRESETN) begin
      xfer_cnt_q <= 16'd0;
    end else if (data_done) begin
      xfer_cnt_q <= xfer_cnt_q + 16'd1;
    end
  end

  // The counter saturates at the limit so a very long stall cannot wrap it back.
  always_ff @(posedge HCLK or negedge HRESETN) begin
    if (!HRESETN) begin
      wait_cnt_q    <= 16'd0;
      timeout_err_q <= 1'b0;
    end else begin
      if (data_entry) begin
        wait_cnt_q <= 16'd0;
      end else if (wait_cycle && wait_cnt_q != TIMEOUT_LIM) begin
        wait_cnt_q <= wait_cnt_q + 16'd1;
      end
      if (wait_cycle && wait_cnt_q == TIMEOUT_LIM - 16'd1) begin
        timeout_err_q <= 1'b1;
      end
    end
  end

  assign CMD_READY   = cmd_ready_q;
  assign RSP_VALID   = (state_q == S_RESP);
  assign RSP_RDATA   = rsp_rdata_q;
  assign RSP_ERROR   = rsp_error_q;

  assign HSEL        = (state_q == S_ADDR);
  assign HTRANS      = (state_q == S_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign HADDR       = cmd_addr_q;
  assign HWRITE      = cmd_write_q;
  assign HSIZE       = cmd_size_q;
  assign HWDATA      = ((state_q == S_DATA) && cmd_write_q) ? cmd_wdata_q : 32'd0;
  assign HBURST      = 3'b000;
  assign HMASTLOCK   = 1'b0;
  assign HPROT       = 4'b0011;

  assign XFER_CNT    = xfer_cnt_q;
  assign TIMEOUT_ERR = timeout_err_q;

endmodule
